drone_telemetria_tx: RTL
========================

// Module: drone_telemetria_tx
// PURPOSE
//   UART 8N1 transmitter sending drone simulator status frames to a host PC.
//   Consumes the simulator's observable state: positions, lives, venceu/perdeu.
//   Serialises it into a fixed 4-byte frame on one tx line, one frame per request.
//   Sits beside simulador_drone at top level. The host replays and logs the game.
// PARAMETERS
//   CLKS_PER_BIT  5208  clock cycles per UART bit (50 MHz / 9600 baud); legal >= 2
// PORTS
//   clock                in   1  system clock, all logic on rising edge
//   reset                in   1  asynchronous, active-high; returns block to IDLE
//   envia                in   1  frame request, sampled only in IDLE (level or pulse)
//   posicao_horizontal   in   4  drone horizontal position
//   posicao_vertical     in   4  drone vertical position
//   vidas                in   3  remaining lives
//   venceu               in   1  win flag
//   perdeu               in   1  loss flag
//   tx                   out  1  UART serial line, idle high, LSB first
//   ocupado              out  1  high while a frame is in progress (state != IDLE)
//   pronto               out  1  one-cycle pulse when a frame completes
//   db_estado            out  4  FSM state for hexa7seg display
// BEHAVIOUR
//   Reset (async): state=IDLE, tx=1, ocupado=0, pronto=0, counters=0, db_estado=0.
//   Frame layout, latched in full on the envia cycle and stable for the whole frame:
//     B0=8'hA5; B1={posicao_horizontal,posicao_vertical};
//     B2={vidas,venceu,perdeu,3'b000}; B3=B0^B1^B2 (XOR checksum).
//   Byte = start bit(0), 8 data bits LSB first, stop bit(1). Each bit lasts exactly
//     CLKS_PER_BIT cycles. Bit counter 0..7; byte index 0..3; baud counter 0..CPB-1.
//   FSM (db_estado): IDLE=0, START=1, DATA=2, STOP=3, DONE=4.
//     IDLE : tx=1; envia=1 at edge N -> latch frame, START from N+1 (tx=0 at N+1).
//     START: tx=0 for CPB cycles -> DATA, bit index 0.
//     DATA : tx=byte[bit]; after CPB cycles, advance bit; after bit 7 -> STOP.
//     STOP : tx=1 for CPB cycles; byte<3 -> START of next byte, no idle gap;
//            byte==3 -> DONE.
//     DONE : tx=1, pronto=1 for exactly one cycle -> IDLE.
//   Total ocupado time per frame = 40*CLKS_PER_BIT + 1 cycles.
//   envia while state != IDLE (including DONE) is ignored; requests are not queued.
//     envia held high re-triggers on the first IDLE cycle after DONE.
//   Input changes during a frame do not affect the frame in flight.
//   Reset mid-frame: tx returns high immediately (async). No partial byte resumes.
//   db_estado values 5..15 are unreachable; any illegal state recovers to IDLE.
// TESTING (CLKS_PER_BIT=4)
//   1 Reset: tx=1, ocupado=0, pronto=0, db_estado=0; hold envia=0 100 cycles -> tx stays 1.
//   2 h=3,v=7,vidas=2,venceu=0,perdeu=0, envia 1 cycle -> bytes A5,37,40,D2 LSB first;
//     ocupado high 161 cycles; pronto single pulse at cycle 161.
//   3 h=F,v=F,vidas=7,venceu=1,perdeu=0 -> bytes A5,FF,F0,AA; stop bits high,
//     back-to-back bytes, no gap.
//   4 Change inputs and pulse envia mid-frame -> frame unchanged, no second frame.
//   5 envia held high continuously -> consecutive frames, one IDLE cycle between them.
//   6 Assert reset during DATA of B1 -> tx=1, db_estado=0 immediately; next envia
//     sends a complete fresh frame.

Source files
------------

// File: rtl/drone_telemetria_tx.sv
// drone_telemetria_tx
//   UART 8N1 transmitter that reports the drone simulator status to a host PC.
//   On each accepted request a fixed 4-byte frame is captured and shifted out
//   on one serial line, LSB first, with the bytes sent back to back:
//     B0 = 8'hA5 (sync marker)
//     B1 = {posicao_horizontal, posicao_vertical}
//     B2 = {vidas, venceu, perdeu, 3'b000}
//     B3 = B0 ^ B1 ^ B2 (XOR checksum)
//
// Ports
//   clock               in   system clock, rising edge
//   reset               in   asynchronous, active-high; forces IDLE
//   envia               in   frame request, only looked at in IDLE
//   posicao_horizontal  in   [3:0] drone horizontal position
//   posicao_vertical    in   [3:0] drone vertical position
//   vidas               in   [2:0] remaining lives
//   venceu              in   win flag
//   perdeu              in   loss flag
//   tx                  out  serial line, idle high
//   ocupado             out  high while a frame is in progress
//   pronto              out  one-cycle pulse when a frame completes
//   db_estado           out  [3:0] FSM state for the 7-segment debug display

module drone_telemetria_tx #(
    parameter int CLKS_PER_BIT = 5208
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       envia,
    input  logic [3:0] posicao_horizontal,
    input  logic [3:0] posicao_vertical,
    input  logic [2:0] vidas,
    input  logic       venceu,
    input  logic       perdeu,
    output logic       tx,
    output logic       ocupado,
    output logic       pronto,
    output logic [3:0] db_estado
);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] START = 3'd1;
    localparam logic [2:0] DATA  = 3'd2;
    localparam logic [2:0] STOP  = 3'd3;
    localparam logic [2:0] DONE  = 3'd4;

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);

    logic [2:0]    state;
    logic [CW-1:0] baud_cnt;
    logic [2:0]    bit_idx;
    logic [1:0]    byte_idx;
    logic [31:0]   frame;

    logic [7:0] byte1;
    logic [7:0] byte2;
    logic [7:0] cur_byte;
    logic       baud_last;

    assign byte1     = {posicao_horizontal, posicao_vertical};
    assign byte2     = {vidas, venceu, perdeu, 3'b000};
    assign cur_byte  = frame[{byte_idx, 3'b000} +: 8];
    assign baud_last = (baud_cnt == BAUD_LAST);

    // The whole frame (checksum included) is frozen at acceptance so input
    // changes during transmission never leak into the frame in flight.
    // Byte index and bit index only advance at the end of a full bit period.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            byte_idx <= '0;
            frame    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    baud_cnt <= '0;
                    bit_idx  <= '0;
                    byte_idx <= '0;
                    if (envia) begin
                        frame <= {8'hA5 ^ byte1 ^ byte2, byte2, byte1, 8'hA5};
                        state <= START;
                    end
                end
                START: begin
                    if (baud_last) begin
                        baud_cnt <= '0;
                        bit_idx  <= '0;
                        state    <= DATA;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (baud_last) begin
                        baud_cnt <= '0;
                        if (bit_idx == 3'd7) begin
                            state <= STOP;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (baud_last) begin
                        baud_cnt <= '0;
                        if (byte_idx == 2'd3) begin
                            state <= DONE;
                        end else begin
                            byte_idx <= byte_idx + 1'b1;
                            state    <= START;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state    <= IDLE;
                    baud_cnt <= '0;
                    bit_idx  <= '0;
                    byte_idx <= '0;
                end
            endcase
        end
    end

    // The line is decoded straight from registered state, so an asynchronous
    // reset returns it high immediately.
    always_comb begin
        tx = 1'b1;
        case (state)
            START:   tx = 1'b0;
            DATA:    tx = cur_byte[bit_idx];
            default: tx = 1'b1;
        endcase
    end

    assign ocupado   = (state != IDLE);
    assign pronto    = (state == DONE);
    assign db_estado = {1'b0, state};

endmodule
